// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the parameterised synchronous FIFO.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Pointer/count width: one extra bit above the address so full and empty differ.
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/param_sync_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, no reset.
module param_sync_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, level flags and sticky error flags
// around a separate storage array; STD (registered) or FWFT read mode.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter int         DEPTH    = 256,
  parameter fifo_mode_e MODE     = FIFO_STD,
  parameter int         AF_LEVEL = DEPTH - 4,
  parameter int         AE_LEVEL = 4,
  localparam int        CW       = fifo_cnt_width(DEPTH),
  localparam int        AW       = CW - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  if (WIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_param
    $error("param_sync_fifo: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] ram_rdata;
  logic             wr_accept;
  logic             rd_accept;

  // Handshake: a write transfers when wr_en && !full, a read/pop when rd_en && !empty,
  // both at the rising clk edge; full/empty come only from registered count, so a
  // same-cycle read never makes room for a write and vice versa.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_accept) wr_ptr_d = wr_ptr_q + ONE_C;
    if (rd_accept) rd_ptr_d = rd_ptr_q + ONE_C;

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    // In FWFT the register tracks the visible head so the output holds after draining.
    if (MODE == FIFO_STD) begin
      if (rd_accept) rd_data_d = ram_rdata;
      rd_valid_d = rd_accept;
    end else begin
      if (!empty) rd_data_d = ram_rdata;
    end

    // A new error in the clearing cycle wins over clr_err.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full)  overflow_d  = 1'b1;
    if (rd_en && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_valid = (MODE == FIFO_FWFT) ? !empty : rd_valid_q;
  assign rd_data  = (MODE == FIFO_FWFT && !empty) ? ram_rdata : rd_data_q;

  param_sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: STD instance checked by a read-data scoreboard,
// FWFT instance checked with directed values, plus flag/count/reset checks.
module tb_param_sync_fifo;
  import fifo_pkg::*;

  logic       clk;
  logic       rst;

  logic       wr_en, rd_en, clr_err;
  logic [7:0] wr_data;
  logic       s_full, s_afull, s_rd_valid, s_empty, s_aempty, s_ovf, s_unf;
  logic [7:0] s_rd_data;
  logic [3:0] s_count;

  logic       f_wr_en, f_rd_en, f_clr_err;
  logic [7:0] f_wr_data;
  logic       f_full, f_afull, f_rd_valid, f_empty, f_aempty, f_ovf, f_unf;
  logic [7:0] f_rd_data;
  logic [3:0] f_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_q[$];

  param_sync_fifo #(.WIDTH(8), .DEPTH(8), .MODE(FIFO_STD), .AF_LEVEL(6), .AE_LEVEL(1)) dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(s_full),
    .almost_full(s_afull), .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .empty(s_empty), .almost_empty(s_aempty), .count(s_count), .overflow(s_ovf),
    .underflow(s_unf), .clr_err(clr_err)
  );

  param_sync_fifo #(.WIDTH(8), .DEPTH(8), .MODE(FIFO_FWFT), .AF_LEVEL(6), .AE_LEVEL(1)) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .full(f_full),
    .almost_full(f_afull), .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
    .empty(f_empty), .almost_empty(f_aempty), .count(f_count), .overflow(f_ovf),
    .underflow(f_unf), .clr_err(f_clr_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: called at a negedge, applies one cycle of stimulus, returns at the next negedge
  task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic clr);
    logic wa, ra;
    wa = we && (model_q.size() < 8);
    ra = re && (model_q.size() > 0);
    if (ra) exp_q.push_back(model_q.pop_front());
    if (wa) model_q.push_back(wd);
    wr_en = we; wr_data = wd; rd_en = re; clr_err = clr;
    @(negedge clk);
    wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic fstep(input logic we, input logic [7:0] wd, input logic re);
    f_wr_en = we; f_wr_data = wd; f_rd_en = re;
    @(negedge clk);
    f_wr_en = 1'b0; f_wr_data = 8'h00; f_rd_en = 1'b0;
  endtask

  // scoreboard monitor for the STD instance
  always @(negedge clk) begin
    if (!rst && s_rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL std_unexpected_valid: got rd_valid=1 data 0x%0h expected no read at %0t",
                 s_rd_data, $time);
      end else begin
        check("std_rd_data", s_rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0; f_wr_data = 8'h00;
    #2;
    check("rst_count", s_count, 0);
    check("rst_empty", s_empty, 1);
    check("rst_full", s_full, 0);
    check("rst_aempty", s_aempty, 1);
    check("rst_afull", s_afull, 0);
    check("rst_rd_valid", s_rd_valid, 0);
    check("rst_rd_data", s_rd_data, 0);
    check("rst_ovf", s_ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // fill
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      check("fill_count", s_count, i + 1);
      check("fill_afull", s_afull, (i + 1 >= 6));
      check("fill_full", s_full, (i == 7));
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_set", s_ovf, 1);
    check("ovf_count", s_count, 8);

    // drain: data checked by the monitor
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_count", s_count, 7 - i);
    end
    check("drain_empty", s_empty, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_set", s_unf, 1);
    check("unf_empty", s_empty, 1);
    check("unf_no_valid", s_rd_valid, 0);
    check("unf_data_hold", s_rd_data, 8'h17);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", s_ovf, 0);
    check("clr_unf", s_unf, 0);

    // wrap: 20 words through a one-deep occupancy
    step(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0);
      check("wrap_count", s_count, 1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("wrap_empty", s_empty, 1);

    // simultaneous requests at the boundaries
    step(1'b1, 8'h40, 1'b1, 1'b0);
    check("sim_empty_count", s_count, 1);
    check("sim_empty_unf", s_unf, 1);
    for (int i = 1; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    check("sim_full_pre", s_full, 1);
    step(1'b1, 8'h50, 1'b1, 1'b0);
    check("sim_full_count", s_count, 7);
    check("sim_full_ovf", s_ovf, 1);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h51, 1'b1, 1'b0);
    check("sim_mid_count", s_count, 4);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("sim_drain_empty", s_empty, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("sim_clr_ovf", s_ovf, 0);
    check("sim_clr_unf", s_unf, 0);

    // FWFT instance
    fstep(1'b1, 8'hA5, 1'b0);
    check("fwft_valid", f_rd_valid, 1);
    check("fwft_data", f_rd_data, 8'hA5);
    check("fwft_not_empty", f_empty, 0);
    fstep(1'b0, 8'h00, 1'b1);
    check("fwft_pop_empty", f_empty, 1);
    check("fwft_pop_valid", f_rd_valid, 0);
    fstep(1'b1, 8'h01, 1'b0);
    fstep(1'b1, 8'h02, 1'b0);
    check("fwft_head1", f_rd_data, 8'h01);
    check("fwft_count2", f_count, 2);
    fstep(1'b0, 8'h00, 1'b1);
    check("fwft_head2", f_rd_data, 8'h02);
    fstep(1'b0, 8'h00, 1'b1);
    check("fwft_drained", f_empty, 1);

    // reset mid-stream at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    check("pre_rst_count", s_count, 5);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_count", s_count, 0);
    check("mid_rst_empty", s_empty, 1);
    check("mid_rst_rd_data", s_rd_data, 0);
    check("mid_rst_afull", s_afull, 0);
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h60, 1'b0, 1'b0);
    check("post_rst_first_write", s_count, 1);
    for (int i = 1; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    check("ovf_again", s_ovf, 1);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    check("clr_with_ovf_keeps", s_ovf, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_alone_clears", s_ovf, 0);
    repeat (8) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("final_empty", s_empty, 1);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 256, entries; power of two, >=4; elaboration error otherwise.
REQ-003 SHALL have parameter MODE, default FIFO_STD, read mode: FIFO_STD (registered read) or FIFO_FWFT (first-word-fall-through).
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-4, almost_full threshold (1..DEPTH).
REQ-005 SHALL have parameter AE_LEVEL, default 4, almost_empty threshold (0..DEPTH-1).
REQ-006 SHALL have ports: clk in 1, sole clock; rst in 1, reset; one clock, reset asynchronous and active-high.
REQ-007 SHALL have ports: wr_en in 1 write request; wr_data in WIDTH write word; full out 1; almost_full out 1.
REQ-008 SHALL have ports: rd_en in 1 read/pop request; rd_data out WIDTH; rd_valid out 1; empty out 1; almost_empty out 1.
REQ-009 SHALL have ports: count out $clog2(DEPTH)+1 occupancy; overflow out 1 sticky; underflow out 1 sticky; clr_err in 1 clears sticky flags.

Function
REQ-010 Write accepted iff wr_en && !full; word stored at write pointer, pointer +1 at that edge.
REQ-011 Read accepted iff rd_en && !empty; read pointer +1 at that edge.
REQ-012 Pointers $clog2(DEPTH)+1 bits; low bits address, MSB wrap bit; wrap DEPTH-1 -> 0 without loss.
REQ-013 count = exact occupancy 0..DEPTH, registered; +1 on write only, -1 on read only, unchanged on simultaneous accepted write+read.
REQ-014 empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL); all derived from registered state, no input-to-flag combinational path.
REQ-015 When full: wr_en rejected even if rd_en same cycle; read proceeds; count becomes DEPTH-1.
REQ-016 When empty: rd_en rejected even if wr_en same cycle; write proceeds; count becomes 1.
REQ-017 FIFO_STD: accepted read drives rd_data with head word one cycle later and pulses rd_valid high exactly that cycle; rd_data holds last value otherwise.
REQ-018 FIFO_FWFT: rd_data shows head word whenever !empty; rd_valid = !empty; rd_en acts as acknowledge/pop; first written word visible the cycle after its write.
REQ-019 overflow set on wr_en && full; underflow set on rd_en && empty; both held until clr_err; set condition in same cycle as clr_err leaves flag set.
REQ-020 Rejected requests change no pointer, count, memory or data output.

Reset
REQ-021 rst asserted: pointers, count, overflow, underflow, rd_valid, rd_data cleared to 0 immediately, independent of clk.
REQ-022 During/after reset: empty=1, full=0, almost_empty=1, almost_full=0; storage array not reset.
REQ-023 Reset mid-operation discards all contents; no read after deassertion returns pre-reset data.
REQ-024 First write accepted on the first clk edge with rst low.

Structure
REQ-025 Shared package fifo_pkg SHALL hold enum fifo_mode_e {FIFO_STD, FIFO_FWFT} and a function for pointer/count width from DEPTH.
REQ-026 Storage SHALL be sub-module param_sync_fifo_ram: DEPTH x WIDTH, synchronous write, asynchronous read, no reset.
REQ-027 Pointer, count, flag and sticky-error logic SHALL live in param_sync_fifo.

Verification (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1 unless stated)
REQ-028 Fill: 8 writes 0x10..0x17, no reads -> count 1..8, almost_full at count 6, full at 8; 9th write (0xFF) -> overflow=1, contents unchanged.
REQ-029 Drain STD: 8 reads after fill -> rd_data 0x10..0x17, each one cycle after rd_en with rd_valid pulse; then rd_en -> underflow=1, empty=1.
REQ-030 Wrap: 20 interleaved write/read cycles, values 0x00..0x13 -> read order identical, count never exceeds 2, pointers wrap twice.
REQ-031 Simultaneous: at count 8 wr_en+rd_en -> write rejected, count 7; at count 0 wr_en+rd_en -> read rejected, count 1; at count 4 both -> count 4.
REQ-032 FWFT: write 0xA5 -> next cycle rd_data=0xA5, rd_valid=1 without rd_en; rd_en -> empty=1, rd_valid=0.
REQ-033 Reset mid-stream: rst asserted between edges at count 5 -> count=0, empty=1 immediately; clr_err with overflow set clears it; clr_err with simultaneous overflow keeps it.
